cp0_regfile: RTL and testbench

//  Parametrised MIPS CP0 register file for the 5-stage CPU core. Sits beside the WB stage.

---
 rtl/cp0_regfile_pkg.sv | 43 ++++
 rtl/cp0_regfile_timer.sv | 51 +++++
 rtl/cp0_regfile.sv | 141 ++++++++++++++
 tb/tb_cp0_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register addresses, ExcCodes and register packing helpers.
package cp0_regfile_pkg;

  typedef enum logic [7:0] {
    CR_BADVADDR = 8'h40,
    CR_COUNT    = 8'h48,
    CR_COMPARE  = 8'h58,
    CR_STATUS   = 8'h60,
    CR_CAUSE    = 8'h68,
    CR_EPC      = 8'h70
  } cp0_addr_e;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [7:0] ip;
    logic [4:0] exccode;
  } cause_t;

  // BEV is hard-wired to 1.
  function automatic logic [31:0] pack_status(input status_t s);
    return {9'b0, 1'b1, 6'b0, s.im, 6'b0, s.exl, s.ie};
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    return {c.bd, c.ti, 14'b0, c.ip, 1'b0, c.exccode, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 timer: prescaler, Count, Compare and the sticky timer-interrupt flag TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [3:0]  div;
  logic        tick;
  logic [31:0] count_next;

  assign tick       = (div == DIV_LAST);
  assign count_next = count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (tick) begin
        count <= count_next;
        div   <= '0;
      end else begin
        div <= div + 4'd1;
      end

      if (compare_we) compare <= wdata;

      // Match is taken on the value Count steps to, so the reset state 0==0 never fires.
      if (compare_we)
        ti <= 1'b0;
      else if (tick && !count_we && (count_next == compare))
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file (Status, Cause, EPC, Count, Compare, optional BadVAddr).
// Optional feature: define CP0_BADVADDR_EN to implement the BadVAddr register.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int EXT_INT_NUM = 6,
  parameter int COUNT_DIV   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mtc0_we,
  input  logic [7:0]             c0_addr,
  input  logic [31:0]            c0_wdata,
  output logic [31:0]            c0_rdata,
  input  logic                   wb_ex,
  input  logic                   wb_bd,
  input  logic [4:0]             wb_excode,
  input  logic [31:0]            wb_pc,
  input  logic [31:0]            wb_badvaddr,
  input  logic                   eret_flush,
  input  logic [EXT_INT_NUM-1:0] ext_int_in,
  output logic [31:0]            c0_epc,
  output logic                   c0_exl,
  output logic                   has_int
);

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exccode;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [5:0]  ext_pad;
  logic [7:0]  ip;

  logic status_we, cause_we, epc_we, count_we, compare_we;
  assign status_we  = mtc0_we && (c0_addr == CR_STATUS);
  assign cause_we   = mtc0_we && (c0_addr == CR_CAUSE);
  assign epc_we     = mtc0_we && (c0_addr == CR_EPC);
  assign count_we   = mtc0_we && (c0_addr == CR_COUNT);
  assign compare_we = mtc0_we && (c0_addr == CR_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (c0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_comb begin
    ext_pad = '0;
    for (int i = 0; i < EXT_INT_NUM; i++) ext_pad[i] = ext_int_in[i];
  end

  assign ip = {ip_hw, ip_sw};

  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      exccode <= '0;
      ip_hw   <= '0;
      ip_sw   <= '0;
      epc     <= '0;
      has_int <= 1'b0;
    end else begin
      ip_hw <= {ext_pad[5] | ti, ext_pad[4:0]};

      if (status_we) begin
        im <= c0_wdata[15:8];
        ie <= c0_wdata[0];
      end

      if (wb_ex)           exl <= 1'b1;
      else if (eret_flush) exl <= 1'b0;
      else if (status_we)  exl <= c0_wdata[1];

      // A nested exception (EXL already set) keeps the original EPC and BD.
      if (wb_ex) begin
        exccode <= wb_excode;
        if (!exl) begin
          epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          bd  <= wb_bd;
        end
      end else if (epc_we) begin
        epc <= c0_wdata;
      end

      if (cause_we) ip_sw <= c0_wdata[9:8];

      has_int <= ~(wb_ex | eret_flush) & ie & ~exl & (|(ip & im));
    end
  end

`ifdef CP0_BADVADDR_EN
  always_ff @(posedge clk) begin
    if (reset)
      badvaddr <= '0;
    else if (wb_ex && ((wb_excode == EXC_ADEL) || (wb_excode == EXC_ADES)))
      badvaddr <= wb_badvaddr;
  end
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^wb_badvaddr;
  assign badvaddr        = '0;
`endif

  status_t status;
  cause_t  cause;
  assign status = '{im: im, exl: exl, ie: ie};
  assign cause  = '{bd: bd, ti: ti, ip: ip, exccode: exccode};

  always_comb begin
    c0_rdata = '0;
    case (c0_addr)
      CR_BADVADDR: c0_rdata = badvaddr;
      CR_COUNT:    c0_rdata = count;
      CR_COMPARE:  c0_rdata = compare;
      CR_STATUS:   c0_rdata = pack_status(status);
      CR_CAUSE:    c0_rdata = pack_cause(cause);
      CR_EPC:      c0_rdata = epc;
      default:     c0_rdata = '0;
    endcase
  end

  assign c0_epc = epc;
  assign c0_exl = exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: vector table for MTC0/read-back plus directed sequences.
module tb_cp0_regfile;

  localparam logic [7:0] A_BADV = 8'h40;
  localparam logic [7:0] A_CNT  = 8'h48;
  localparam logic [7:0] A_CMP  = 8'h58;
  localparam logic [7:0] A_STS  = 8'h60;
  localparam logic [7:0] A_CAU  = 8'h68;
  localparam logic [7:0] A_EPC  = 8'h70;

  logic        clk = 1'b0;
  logic        reset;
  logic        mtc0_we;
  logic [7:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic [31:0] c0_rdata;
  logic        wb_ex;
  logic        wb_bd;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        eret_flush;
  logic [5:0]  ext_int_in;
  logic [31:0] c0_epc;
  logic        c0_exl;
  logic        has_int;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cp0_regfile #(.EXT_INT_NUM(6), .COUNT_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .mtc0_we     (mtc0_we),
    .c0_addr     (c0_addr),
    .c0_wdata    (c0_wdata),
    .c0_rdata    (c0_rdata),
    .wb_ex       (wb_ex),
    .wb_bd       (wb_bd),
    .wb_excode   (wb_excode),
    .wb_pc       (wb_pc),
    .wb_badvaddr (wb_badvaddr),
    .eret_flush  (eret_flush),
    .ext_int_in  (ext_int_in),
    .c0_epc      (c0_epc),
    .c0_exl      (c0_exl),
    .has_int     (has_int)
  );

  typedef struct {
    logic [7:0]  wr_addr;
    logic [31:0] wdata;
    logic [7:0]  rd_addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    mtc0_we  = 1'b1;
    c0_addr  = a;
    c0_wdata = d;
    tick();
    mtc0_we  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    c0_addr = a;
    #1;
    check(name, c0_rdata, exp);
  endtask

  task automatic do_reset();
    mtc0_we = 0; c0_addr = 0; c0_wdata = 0;
    wb_ex = 0; wb_bd = 0; wb_excode = 0; wb_pc = 0; wb_badvaddr = 0;
    eret_flush = 0; ext_int_in = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                     input logic [31:0] badv);
    wb_ex = 1'b1; wb_pc = pc; wb_bd = bd; wb_excode = code; wb_badvaddr = badv;
    tick();
    wb_ex = 1'b0; wb_bd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{A_STS,   32'hFFFFFFFF, A_STS,   32'h0040FF03, "status_all_ones"};
    vecs[1] = '{A_STS,   32'h00000000, A_STS,   32'h00400000, "status_zero"};
    vecs[2] = '{A_CAU,   32'hFFFFFFFF, A_CAU,   32'h00000300, "cause_only_ip10"};
    vecs[3] = '{A_CAU,   32'h00000000, A_CAU,   32'h00000000, "cause_zero"};
    vecs[4] = '{A_EPC,   32'h12345678, A_EPC,   32'h12345678, "epc_write"};
    vecs[5] = '{A_CMP,   32'hAAAA5555, A_CMP,   32'hAAAA5555, "compare_write"};
    vecs[6] = '{A_BADV,  32'hDEADBEEF, A_BADV,  32'h00000000, "badvaddr_ro"};
    vecs[7] = '{8'h00,   32'hFFFFFFFF, 8'h00,   32'h00000000, "unimpl_addr"};
    vecs[8] = '{8'h61,   32'hFFFFFFFF, A_STS,   32'h00400000, "status_sel1_no_alias"};
    vecs[9] = '{8'h71,   32'hFFFFFFFF, A_EPC,   32'h12345678, "epc_sel1_no_alias"};

    // Reset state
    do_reset();
    rd_check("rst_badvaddr", A_BADV, 32'h0);
    rd_check("rst_count",    A_CNT,  32'h0);
    rd_check("rst_compare",  A_CMP,  32'h0);
    rd_check("rst_status",   A_STS,  32'h00400000);
    rd_check("rst_cause",    A_CAU,  32'h0);
    rd_check("rst_epc",      A_EPC,  32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    check("rst_exl",     {31'b0, c0_exl},  32'h0);
    check("rst_c0_epc",  c0_epc,           32'h0);

    // MTC0 / read-back table
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].wr_addr, vecs[i].wdata);
      rd_check(vecs[i].name, vecs[i].rd_addr, vecs[i].exp);
    end

    // Exception entry in a delay slot, then a nested exception
    do_reset();
    exc(32'hBFC00100, 1'b1, 5'h0c, 32'h0);
    check("ex_epc", c0_epc, 32'hBFC000FC);
    check("ex_exl", {31'b0, c0_exl}, 32'h1);
    rd_check("ex_cause",  A_CAU, 32'h80000030);
    rd_check("ex_status", A_STS, 32'h00400002);
    exc(32'h00000200, 1'b0, 5'h08, 32'h0);
    check("nested_epc_held", c0_epc, 32'hBFC000FC);
    rd_check("nested_cause", A_CAU, 32'h80000020);
    eret_flush = 1'b1; tick(); eret_flush = 1'b0;
    check("eret_exl", {31'b0, c0_exl}, 32'h0);

    // Count wrap and Compare match
    do_reset();
    wr(A_CNT, 32'hFFFFFFFE);
    wr(A_CMP, 32'h00000001);
    rd_check("cnt_hold_phase", A_CNT, 32'hFFFFFFFE);
    tick(); tick(); tick();
    rd_check("cnt_wrap", A_CNT, 32'h00000000);
    tick();
    rd_check("ti_not_yet", A_CAU, 32'h00000000);
    tick();
    rd_check("cnt_one", A_CNT, 32'h00000001);
    rd_check("ti_set", A_CAU, 32'h40000000);
    tick();
    rd_check("ip7_set", A_CAU, 32'h40008000);
    wr(A_CMP, 32'h00000005);
    rd_check("ti_cleared", A_CAU, 32'h00008000);
    tick();
    rd_check("ip7_cleared", A_CAU, 32'h00000000);

    // External interrupt and has_int gating
    do_reset();
    wr(A_STS, 32'h0000FF01);
    ext_int_in = 6'b000001;
    tick();
    rd_check("ip2_latency", A_CAU, 32'h00000400);
    check("has_int_not_yet", {31'b0, has_int}, 32'h0);
    tick();
    check("has_int_set", {31'b0, has_int}, 32'h1);
    wr(A_STS, 32'h0000FF03);
    check("mtc0_exl", {31'b0, c0_exl}, 32'h1);
    tick();
    check("has_int_exl_mask", {31'b0, has_int}, 32'h0);
    wr(A_STS, 32'h0000FF01);
    tick();
    check("has_int_reenabled", {31'b0, has_int}, 32'h1);
    eret_flush = 1'b1; tick(); eret_flush = 1'b0;
    check("has_int_eret_kill", {31'b0, has_int}, 32'h0);
    tick();
    check("has_int_after_eret", {31'b0, has_int}, 32'h1);
    ext_int_in = 6'b000000;
    tick(); tick();
    check("has_int_dropped", {31'b0, has_int}, 32'h0);
    wr(A_CAU, 32'h00000100);
    tick();
    check("has_int_sw_ip0", {31'b0, has_int}, 32'h1);

    // Same-cycle priority: wb_ex over MTC0 EPC and over eret_flush
    do_reset();
    mtc0_we = 1'b1; c0_addr = A_EPC; c0_wdata = 32'h00001234;
    wb_ex = 1'b1; wb_pc = 32'h00000300; wb_bd = 1'b0; wb_excode = 5'h0c;
    #1;
    check("no_write_through", c0_rdata, 32'h0);
    tick();
    mtc0_we = 1'b0; wb_ex = 1'b0;
    check("ex_beats_mtc0_epc", c0_epc, 32'h00000300);
    check("ex_beats_mtc0_exl", {31'b0, c0_exl}, 32'h1);
    eret_flush = 1'b1; tick(); eret_flush = 1'b0;
    wb_ex = 1'b1; eret_flush = 1'b1; wb_pc = 32'h00000400;
    tick();
    wb_ex = 1'b0; eret_flush = 1'b0;
    check("ex_beats_eret_epc", c0_epc, 32'h00000400);
    check("ex_beats_eret_exl", {31'b0, c0_exl}, 32'h1);

    // BadVAddr
    do_reset();
`ifdef CP0_BADVADDR_EN
    exc(32'h00000500, 1'b0, 5'h04, 32'h80000003);
    rd_check("badv_adel_load", A_BADV, 32'h80000003);
    exc(32'h00000600, 1'b0, 5'h0c, 32'h00001234);
    rd_check("badv_ov_hold", A_BADV, 32'h80000003);
    wr(A_BADV, 32'hFFFFFFFF);
    rd_check("badv_mtc0_ignored", A_BADV, 32'h80000003);
    exc(32'h00000700, 1'b0, 5'h05, 32'h00000011);
    rd_check("badv_ades_exl1", A_BADV, 32'h00000011);
`else
    exc(32'h00000500, 1'b0, 5'h04, 32'h80000003);
    rd_check("badv_absent", A_BADV, 32'h00000000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
